// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter
//  Purpose  : Transmit end of the common data bus. Each functional-unit source
//             owns a small result FIFO; one queued result per cycle wins a
//             round-robin grant and is broadcast (BCEN/BClabel/BCdata) to the
//             reservation stations. Label 0 means "no producer" and is
//             accepted but never queued or broadcast.
//  Options  : `define CDB_BYPASS_EN lets a fresh result skip an all-empty
//             FIFO set and load the broadcast register directly.
//  Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
    parameter int NUM_SRC = 3,
    parameter int DATA_W  = 32,
    parameter int LABEL_W = 4,
    parameter int DEPTH   = 2
) (
    input  logic                         clk,
    input  logic                         nRST,
    input  logic                         flush,
    input  logic [NUM_SRC-1:0]           src_valid,
    input  logic [NUM_SRC*LABEL_W-1:0]   src_label,
    input  logic [NUM_SRC*DATA_W-1:0]    src_data,
    output logic [NUM_SRC-1:0]           src_ready,
    output logic                         BCEN,
    output logic [LABEL_W-1:0]           BClabel,
    output logic [DATA_W-1:0]            BCdata
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int RR_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [RR_W:0]    NSRC_X   = (RR_W + 1)'(NUM_SRC);
    localparam logic [RR_W-1:0]  LAST_SRC = RR_W'(NUM_SRC - 1);

    // Storage and pointers
    logic [LABEL_W-1:0] mem_label_q [NUM_SRC][DEPTH];
    logic [LABEL_W-1:0] mem_label_d [NUM_SRC][DEPTH];
    logic [DATA_W-1:0]  mem_data_q  [NUM_SRC][DEPTH];
    logic [DATA_W-1:0]  mem_data_d  [NUM_SRC][DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q [NUM_SRC];
    logic [PTR_W-1:0]   wr_ptr_d [NUM_SRC];
    logic [PTR_W-1:0]   rd_ptr_q [NUM_SRC];
    logic [PTR_W-1:0]   rd_ptr_d [NUM_SRC];
    logic [CNT_W-1:0]   count_q  [NUM_SRC];
    logic [CNT_W-1:0]   count_d  [NUM_SRC];
    logic [RR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic               bcen_q, bcen_d;
    logic [LABEL_W-1:0] bclabel_q, bclabel_d;
    logic [DATA_W-1:0]  bcdata_q, bcdata_d;

    logic [NUM_SRC-1:0] full, empty, label_nz, req, push, pop;
    logic               bypass_mode;
    logic               grant_vld;
    logic [RR_W-1:0]    grant_idx;
    logic [LABEL_W-1:0] head_label;
    logic [DATA_W-1:0]  head_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_status
            assign full[gi]      = (count_q[gi] == FULL_CNT);
            assign empty[gi]     = (count_q[gi] == '0);
            assign label_nz[gi]  = |src_label[gi*LABEL_W +: LABEL_W];
            // Readiness depends on the stored count only: no pass-through.
            assign src_ready[gi] = ~full[gi];
        end
    endgenerate

`ifdef CDB_BYPASS_EN
    // With every FIFO empty, live inputs compete directly for the bus.
    assign bypass_mode = (&empty) & ~flush;
    assign req         = bypass_mode ? (src_valid & label_nz) : ~empty;
    assign head_label  = bypass_mode ? src_label[grant_idx*LABEL_W +: LABEL_W]
                                     : mem_label_q[grant_idx][rd_ptr_q[grant_idx]];
    assign head_data   = bypass_mode ? src_data[grant_idx*DATA_W +: DATA_W]
                                     : mem_data_q[grant_idx][rd_ptr_q[grant_idx]];
`else
    assign bypass_mode = 1'b0;
    assign req         = ~empty;
    assign head_label  = mem_label_q[grant_idx][rd_ptr_q[grant_idx]];
    assign head_data   = mem_data_q[grant_idx][rd_ptr_q[grant_idx]];
`endif

    // Round-robin search from rr_ptr upward, wrapping modulo NUM_SRC.
    always_comb begin
        logic [RR_W:0] idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = {1'b0, rr_ptr_q} + (RR_W + 1)'(k);
            if (idx >= NSRC_X) idx = idx - NSRC_X;
            if (!grant_vld && req[idx[RR_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = idx[RR_W-1:0];
            end
        end
    end

    // Push/pop qualification; flush kills both, a bypass winner is not queued.
    always_comb begin
        pop  = '0;
        push = src_valid & ~full & label_nz & {NUM_SRC{~flush}};
        if (grant_vld && !flush) begin
            if (bypass_mode) push[grant_idx] = 1'b0;
            else             pop[grant_idx]  = 1'b1;
        end
    end

    // FIFO next state: write at wr_ptr, advance pointers, track occupancy.
    always_comb begin
        mem_label_d = mem_label_q;
        mem_data_d  = mem_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (flush) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                count_d[i]  = '0;
            end else begin
                if (push[i]) begin
                    mem_label_d[i][wr_ptr_q[i]] = src_label[i*LABEL_W +: LABEL_W];
                    mem_data_d[i][wr_ptr_q[i]]  = src_data[i*DATA_W +: DATA_W];
                    wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
                end
                if (pop[i]) rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
                case ({push[i], pop[i]})
                    2'b10:   count_d[i] = count_q[i] + 1'b1;
                    2'b01:   count_d[i] = count_q[i] - 1'b1;
                    default: count_d[i] = count_q[i];
                endcase
            end
        end
    end

    // Pointer advance past the winner and broadcast register load.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        bcen_d    = 1'b0;
        bclabel_d = '0;
        bcdata_d  = bcdata_q;
        if (flush) begin
            rr_ptr_d = '0;
        end else if (grant_vld) begin
            rr_ptr_d  = (grant_idx == LAST_SRC) ? '0 : grant_idx + 1'b1;
            bcen_d    = 1'b1;
            bclabel_d = head_label;
            bcdata_d  = head_data;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    mem_label_q[i][j] <= '0;
                    mem_data_q[i][j]  <= '0;
                end
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            rr_ptr_q  <= '0;
            bcen_q    <= 1'b0;
            bclabel_q <= '0;
            bcdata_q  <= '0;
        end else begin
            mem_label_q <= mem_label_d;
            mem_data_q  <= mem_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rr_ptr_q    <= rr_ptr_d;
            bcen_q      <= bcen_d;
            bclabel_q   <= bclabel_d;
            bcdata_q    <= bcdata_d;
        end
    end

    assign BCEN    = bcen_q;
    assign BClabel = bclabel_q;
    assign BCdata  = bcdata_q;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cdb_arbiter
//  Purpose  : Directed self-checking bench for cdb_arbiter (default build).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

    localparam int NUM_SRC = 3;
    localparam int DATA_W  = 32;
    localparam int LABEL_W = 4;
    localparam int DEPTH   = 2;

    logic                       clk = 1'b0;
    logic                       nRST = 1'b0;
    logic                       flush = 1'b0;
    logic [NUM_SRC-1:0]         src_valid = '0;
    logic [NUM_SRC*LABEL_W-1:0] src_label = '0;
    logic [NUM_SRC*DATA_W-1:0]  src_data = '0;
    logic [NUM_SRC-1:0]         src_ready;
    logic                       BCEN;
    logic [LABEL_W-1:0]         BClabel;
    logic [DATA_W-1:0]          BCdata;

    int checks = 0;
    int errors = 0;

    logic             mon_en = 1'b0;
    logic [LABEL_W-1:0] bc_labels[$];

    cdb_arbiter #(
        .NUM_SRC (NUM_SRC),
        .DATA_W  (DATA_W),
        .LABEL_W (LABEL_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .nRST      (nRST),
        .flush     (flush),
        .src_valid (src_valid),
        .src_label (src_label),
        .src_data  (src_data),
        .src_ready (src_ready),
        .BCEN      (BCEN),
        .BClabel   (BClabel),
        .BCdata    (BCdata)
    );

    always #5 clk = ~clk;

    // Record every broadcast label while the monitor is enabled.
    always @(negedge clk) if (mon_en && BCEN) bc_labels.push_back(BClabel);

    task automatic drive(input int s, input logic v, input logic [LABEL_W-1:0] l,
                         input logic [DATA_W-1:0] d);
        src_valid[s]                = v;
        src_label[s*LABEL_W +: LABEL_W] = l;
        src_data[s*DATA_W +: DATA_W]    = d;
    endtask

    task automatic clear_inputs();
        src_valid = '0;
        src_label = '0;
        src_data  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        nRST  = 1'b0;
        flush = 1'b0;
        clear_inputs();
        @(negedge clk);
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        checks++; if (BCEN !== 1'b0) begin errors++; $display("FAIL reset_bcen: got %b expected 0", BCEN); end
        checks++; if (BClabel !== 4'd0) begin errors++; $display("FAIL reset_label: got %0d expected 0", BClabel); end
        checks++; if (BCdata !== 32'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", BCdata); end
        checks++; if (src_ready !== 3'b111) begin errors++; $display("FAIL reset_ready: got %b expected 111", src_ready); end
        nRST = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        drive(1, 1'b1, 4'd5, 32'h0000_00AA);
        @(negedge clk);
        drive(1, 1'b0, 4'd0, 32'h0);
        checks++; if (BCEN !== 1'b0) begin errors++; $display("FAIL single_early: got %b expected 0", BCEN); end
        @(negedge clk);
        checks++; if (BCEN !== 1'b1) begin errors++; $display("FAIL single_bcen: got %b expected 1", BCEN); end
        checks++; if (BClabel !== 4'd5) begin errors++; $display("FAIL single_label: got %0d expected 5", BClabel); end
        checks++; if (BCdata !== 32'hAA) begin errors++; $display("FAIL single_data: got %h expected 000000aa", BCdata); end
        @(negedge clk);
        checks++; if (BCEN !== 1'b0) begin errors++; $display("FAIL single_drop: got %b expected 0", BCEN); end
        checks++; if (BClabel !== 4'd0) begin errors++; $display("FAIL single_label_clr: got %0d expected 0", BClabel); end
        checks++; if (BCdata !== 32'hAA) begin errors++; $display("FAIL single_data_hold: got %h expected 000000aa", BCdata); end
    endtask

    task automatic test_contention();
        logic [LABEL_W-1:0] exp_l [3];
        logic [DATA_W-1:0]  exp_d [3];
        exp_l = '{4'd1, 4'd2, 4'd3};
        exp_d = '{32'h11, 32'h22, 32'h33};
        do_reset();
        drive(0, 1'b1, 4'd1, 32'h11);
        drive(1, 1'b1, 4'd2, 32'h22);
        drive(2, 1'b1, 4'd3, 32'h33);
        @(negedge clk);
        clear_inputs();
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checks++; if (BCEN !== 1'b1 || BClabel !== exp_l[n] || BCdata !== exp_d[n]) begin
                errors++; $display("FAIL contention_%0d: got en=%b label=%0d data=%h expected en=1 label=%0d data=%h",
                                   n, BCEN, BClabel, BCdata, exp_l[n], exp_d[n]);
            end
        end
        @(negedge clk);
        checks++; if (BCEN !== 1'b0) begin errors++; $display("FAIL contention_idle: got %b expected 0", BCEN); end
        // rr_ptr back at 0: source 0 must win over source 2.
        drive(0, 1'b1, 4'd4, 32'h44);
        drive(2, 1'b1, 4'd6, 32'h66);
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        checks++; if (BCEN !== 1'b1 || BClabel !== 4'd4) begin errors++; $display("FAIL rr_wrap_first: got en=%b label=%0d expected en=1 label=4", BCEN, BClabel); end
        @(negedge clk);
        checks++; if (BCEN !== 1'b1 || BClabel !== 4'd6) begin errors++; $display("FAIL rr_wrap_second: got en=%b label=%0d expected en=1 label=6", BCEN, BClabel); end
    endtask

    task automatic test_backpressure();
        logic [LABEL_W-1:0] got [$];
        logic [LABEL_W-1:0] exp_l [3];
        exp_l = '{4'd4, 4'd5, 4'd6};
        do_reset();
        bc_labels.delete();
        mon_en = 1'b1;
        drive(1, 1'b1, 4'd9,  32'h90);
        drive(2, 1'b1, 4'd10, 32'hA0);
        @(negedge clk);
        drive(0, 1'b1, 4'd4, 32'h40);
        checks++; if (src_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_ready_a: got %b expected 1", src_ready[0]); end
        @(negedge clk);
        drive(0, 1'b1, 4'd5, 32'h50);
        checks++; if (src_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_ready_b: got %b expected 1", src_ready[0]); end
        @(negedge clk);
        checks++; if (src_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_full: got %b expected 0", src_ready[0]); end
        drive(0, 1'b1, 4'd6, 32'h60);
        @(negedge clk);
        checks++; if (src_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_after_pop: got %b expected 1", src_ready[0]); end
        @(negedge clk);
        clear_inputs();
        repeat (12) @(negedge clk);
        mon_en = 1'b0;
        foreach (bc_labels[k]) if (bc_labels[k] >= 4'd4 && bc_labels[k] <= 4'd6) got.push_back(bc_labels[k]);
        checks++; if (got.size() != 3) begin errors++; $display("FAIL bp_count: got %0d expected 3", got.size()); end
        for (int n = 0; n < 3; n++) begin
            if (n < got.size()) begin
                checks++; if (got[n] !== exp_l[n]) begin errors++; $display("FAIL bp_order_%0d: got %0d expected %0d", n, got[n], exp_l[n]); end
            end
        end
    endtask

    task automatic test_label0();
        do_reset();
        drive(2, 1'b1, 4'd0, 32'h1234);
        checks++; if (src_ready !== 3'b111) begin errors++; $display("FAIL label0_ready: got %b expected 111", src_ready); end
        @(negedge clk);
        checks++; if (src_ready !== 3'b111) begin errors++; $display("FAIL label0_ready_after: got %b expected 111", src_ready); end
        clear_inputs();
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            checks++; if (BCEN !== 1'b0) begin errors++; $display("FAIL label0_no_bc_%0d: got %b expected 0", n, BCEN); end
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(0, 1'b1, 4'd1, 32'h1);
        drive(1, 1'b1, 4'd2, 32'h2);
        drive(2, 1'b1, 4'd3, 32'h3);
        @(negedge clk);
        drive(0, 1'b1, 4'd4, 32'h4);
        drive(1, 1'b1, 4'd5, 32'h5);
        drive(2, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
        // Four entries queued now; a push during flush must be dropped.
        clear_inputs();
        drive(2, 1'b1, 4'd6, 32'h6);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        clear_inputs();
        checks++; if (BCEN !== 1'b0) begin errors++; $display("FAIL flush_bcen: got %b expected 0", BCEN); end
        checks++; if (BClabel !== 4'd0) begin errors++; $display("FAIL flush_label: got %0d expected 0", BClabel); end
        checks++; if (src_ready !== 3'b111) begin errors++; $display("FAIL flush_ready: got %b expected 111", src_ready); end
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            checks++; if (BCEN !== 1'b0) begin errors++; $display("FAIL flush_quiet_%0d: got %b expected 0", n, BCEN); end
        end
        drive(1, 1'b1, 4'd7, 32'h77);
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        checks++; if (BCEN !== 1'b1 || BClabel !== 4'd7 || BCdata !== 32'h77) begin
            errors++; $display("FAIL flush_repush: got en=%b label=%0d data=%h expected en=1 label=7 data=00000077", BCEN, BClabel, BCdata);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(0, 1'b1, 4'd1, 32'h10);
        drive(1, 1'b1, 4'd2, 32'h20);
        drive(2, 1'b1, 4'd3, 32'h30);
        @(negedge clk);
        clear_inputs();
        drive(0, 1'b1, 4'd4, 32'h40);
        @(negedge clk);
        clear_inputs();
        checks++; if (BCEN !== 1'b1 || BClabel !== 4'd1) begin errors++; $display("FAIL areset_pre: got en=%b label=%0d expected en=1 label=1", BCEN, BClabel); end
        #2 nRST = 1'b0;
        #1;
        checks++; if (BCEN !== 1'b0) begin errors++; $display("FAIL areset_bcen: got %b expected 0", BCEN); end
        checks++; if (BClabel !== 4'd0) begin errors++; $display("FAIL areset_label: got %0d expected 0", BClabel); end
        checks++; if (BCdata !== 32'd0) begin errors++; $display("FAIL areset_data: got %h expected 0", BCdata); end
        checks++; if (src_ready !== 3'b111) begin errors++; $display("FAIL areset_ready: got %b expected 111", src_ready); end
        @(negedge clk);
        nRST = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            checks++; if (BCEN !== 1'b0) begin errors++; $display("FAIL areset_stale_%0d: got %b expected 0", n, BCEN); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_label0();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
